// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: F-stage fetch PC owner.
// Holds the fetch PC and selects the next PC from the sequential, branch,
// jump, register-jump, exception and ERET sources. It issues a valid/ready
// request to instruction memory. A control redirect that arrives while the
// current fetch cannot fire is buffered until that fetch (the delay slot)
// is accepted. A misaligned or out-of-window fetch PC is flagged as AdEL,
// and no request is issued for it.
module pc_fetch_unit #(
    parameter int              WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_3000,
    parameter logic [WIDTH-1:0] EXC_BASE = 32'h0000_4180,
    parameter logic [WIDTH-1:0] IMEM_LO  = 32'h0000_3000,
    parameter logic [WIDTH-1:0] IMEM_HI  = 32'h0000_6FFC
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic [2:0]       npc_op,
    input  logic [WIDTH-1:0] pc_d,
    input  logic [WIDTH-1:0] ext_imm,
    input  logic [25:0]      imm26,
    input  logic [WIDTH-1:0] rs_val,
    input  logic             req,
    input  logic [WIDTH-1:0] epc,
    input  logic             if_ready,
    output logic             if_valid,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc8,
    output logic             if_adel,
    output logic             pend_valid
);

    localparam logic [2:0] OP_SEQ  = 3'b000;
    localparam logic [2:0] OP_BR   = 3'b001;
    localparam logic [2:0] OP_J    = 3'b010;
    localparam logic [2:0] OP_JR   = 3'b011;
    localparam logic [2:0] OP_ERET = 3'b100;

    localparam logic [WIDTH-1:0] PC_STEP  = WIDTH'(32'd4);
    localparam logic [WIDTH-1:0] LINK_OFS = WIDTH'(32'd8);
    localparam logic [WIDTH-1:0] ZERO_W   = WIDTH'(32'd0);

    logic [WIDTH-1:0] pc_r;
    logic             valid_r;
    logic             pend_valid_r;
    logic [WIDTH-1:0] pend_tgt_r;

    logic             is_eret_s;
    logic             is_redir_s;
    logic             adel_s;
    logic             fire_s;
    logic [WIDTH-1:0] target_s;
    logic [WIDTH-1:0] pc_nxt_s;
    logic             pend_valid_nxt_s;
    logic [WIDTH-1:0] pend_tgt_nxt_s;

    assign pc         = pc_r;
    assign pend_valid = pend_valid_r;
    assign if_adel    = adel_s;
    assign pc8        = pc_d + LINK_OFS;

    assign is_eret_s = (npc_op == OP_ERET);
    assign adel_s    = (pc_r[1:0] != 2'b00) | (pc_r < IMEM_LO) | (pc_r > IMEM_HI);
    // An exception or an ERET withdraws the request immediately, because
    // pc_r is about to be overwritten without the current fetch completing.
    assign if_valid  = valid_r & ~stall & ~adel_s & ~req & ~is_eret_s;
    assign fire_s    = if_valid & if_ready;

    // Decode the control-transfer op and compute its target address.
    always_comb begin
        is_redir_s = 1'b0;
        target_s   = ZERO_W;
        case (npc_op)
            OP_BR: begin
                is_redir_s = 1'b1;
                target_s   = pc_d + PC_STEP + (ext_imm << 2);
            end
            OP_J: begin
                is_redir_s = 1'b1;
                target_s   = {pc_d[WIDTH-1:28], imm26, 2'b00};
            end
            OP_JR: begin
                is_redir_s = 1'b1;
                target_s   = rs_val;
            end
            OP_SEQ: begin
                is_redir_s = 1'b0;
                target_s   = ZERO_W;
            end
            default: begin
                is_redir_s = 1'b0;
                target_s   = ZERO_W;
            end
        endcase
    end

    // Apply the priority list to get the next PC and the next pending-redirect state.
    always_comb begin
        pc_nxt_s         = pc_r;
        pend_valid_nxt_s = pend_valid_r;
        pend_tgt_nxt_s   = pend_tgt_r;
        if (req) begin
            pc_nxt_s         = EXC_BASE;
            pend_valid_nxt_s = 1'b0;
        end else if (is_eret_s) begin
            pc_nxt_s         = epc;
            pend_valid_nxt_s = 1'b0;
        end else if (fire_s && pend_valid_r) begin
            // The branch owning the buffered target is still held in D, so
            // its op is still visible this cycle. It must not be applied twice.
            pc_nxt_s         = pend_tgt_r;
            pend_valid_nxt_s = 1'b0;
        end else if (fire_s && is_redir_s) begin
            pc_nxt_s = target_s;
        end else if (fire_s) begin
            pc_nxt_s = pc_r + PC_STEP;
        end else if (is_redir_s) begin
            // The delay slot has not been fetched yet, so keep the target until it fires.
            pend_valid_nxt_s = 1'b1;
            pend_tgt_nxt_s   = target_s;
        end else begin
            pc_nxt_s         = pc_r;
            pend_valid_nxt_s = pend_valid_r;
            pend_tgt_nxt_s   = pend_tgt_r;
        end
    end

    // Fetch PC, request-enable and pending-redirect state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r         <= RESET_PC;
            valid_r      <= 1'b0;
            pend_valid_r <= 1'b0;
            pend_tgt_r   <= ZERO_W;
        end else begin
            pc_r         <= pc_nxt_s;
            valid_r      <= 1'b1;
            pend_valid_r <= pend_valid_nxt_s;
            pend_tgt_r   <= pend_tgt_nxt_s;
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit.
// Inputs change just after a falling edge and take effect at the next rising edge.
// Outputs are sampled on falling edges.
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic [2:0]  npc_op;
    logic [31:0] pc_d;
    logic [31:0] ext_imm;
    logic [25:0] imm26;
    logic [31:0] rs_val;
    logic        req;
    logic [31:0] epc;
    logic        if_ready;
    logic        if_valid;
    logic [31:0] pc;
    logic [31:0] pc8;
    logic        if_adel;
    logic        pend_valid;

    int total;
    int bad;

    pc_fetch_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .npc_op     (npc_op),
        .pc_d       (pc_d),
        .ext_imm    (ext_imm),
        .imm26      (imm26),
        .rs_val     (rs_val),
        .req        (req),
        .epc        (epc),
        .if_ready   (if_ready),
        .if_valid   (if_valid),
        .pc         (pc),
        .pc8        (pc8),
        .if_adel    (if_adel),
        .pend_valid (pend_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0; stall = 1'b0; npc_op = 3'b000; pc_d = 32'h0; ext_imm = 32'h0;
        imm26 = 26'h0; rs_val = 32'h0; req = 1'b0; epc = 32'h0; if_ready = 1'b1;
        #12;
        total++; if (pc !== 32'h3000) begin bad++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h3000); end
        total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", if_valid); end
        total++; if (pend_valid !== 1'b0) begin bad++; $display("FAIL reset_pend got=%b exp=0", pend_valid); end
        @(negedge clk); rst_n = 1'b1; #1;
        total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL first_cycle_valid got=%b exp=0", if_valid); end
        @(negedge clk);
        total++; if (pc !== 32'h3000 || if_valid !== 1'b1) begin bad++; $display("FAIL seq0 pc=%h v=%b exp=3000/1", pc, if_valid); end
        @(negedge clk);
        total++; if (pc !== 32'h3004) begin bad++; $display("FAIL seq1 got=%h exp=3004", pc); end
        @(negedge clk);
        total++; if (pc !== 32'h3008) begin bad++; $display("FAIL seq2 got=%h exp=3008", pc); end
    endtask

    task automatic test_branch_jump();
        pc_d = 32'h3010; ext_imm = 32'h3; npc_op = 3'b001; #1;
        total++; if (pc8 !== 32'h3018) begin bad++; $display("FAIL pc8 got=%h exp=3018", pc8); end
        @(negedge clk);
        total++; if (pc !== 32'h3020) begin bad++; $display("FAIL br_target got=%h exp=3020", pc); end
        pc_d = 32'h3000; imm26 = 26'h000C10; npc_op = 3'b010;
        @(negedge clk);
        total++; if (pc !== 32'h3040) begin bad++; $display("FAIL j_target got=%h exp=3040", pc); end
        npc_op = 3'b000;
        @(negedge clk);
        total++; if (pc !== 32'h3044) begin bad++; $display("FAIL post_j_seq got=%h exp=3044", pc); end
    endtask

    task automatic test_pending_jr();
        if_ready = 1'b0; npc_op = 3'b011; rs_val = 32'h3100;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (pend_valid !== 1'b1 || pc !== 32'h3044 || if_valid !== 1'b1) begin
                bad++; $display("FAIL jr_hold%0d pend=%b pc=%h v=%b exp=1/3044/1", i, pend_valid, pc, if_valid);
            end
        end
        if_ready = 1'b1;
        @(negedge clk);
        total++; if (pc !== 32'h3100 || pend_valid !== 1'b0) begin bad++; $display("FAIL jr_release pc=%h pend=%b exp=3100/0", pc, pend_valid); end
        npc_op = 3'b000;
        @(negedge clk);
        total++; if (pc !== 32'h3104) begin bad++; $display("FAIL jr_after got=%h exp=3104", pc); end
    endtask

    task automatic test_req_over_pending();
        if_ready = 1'b0; npc_op = 3'b010; pc_d = 32'h3000; imm26 = 26'h000C40;
        @(negedge clk);
        total++; if (pend_valid !== 1'b1 || pc !== 32'h3104) begin bad++; $display("FAIL req_setup pend=%b pc=%h exp=1/3104", pend_valid, pc); end
        req = 1'b1; #1;
        total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL req_cancel got=%b exp=0", if_valid); end
        @(negedge clk);
        total++; if (pc !== 32'h4180 || pend_valid !== 1'b0) begin bad++; $display("FAIL req_redirect pc=%h pend=%b exp=4180/0", pc, pend_valid); end
        req = 1'b0; npc_op = 3'b000; if_ready = 1'b1;
        @(negedge clk);
        total++; if (pc !== 32'h4184) begin bad++; $display("FAIL handler_seq got=%h exp=4184", pc); end
    endtask

    task automatic test_stall_eret();
        stall = 1'b1;
        @(negedge clk);
        total++; if (pc !== 32'h4184 || if_valid !== 1'b0) begin bad++; $display("FAIL stall_hold pc=%h v=%b exp=4184/0", pc, if_valid); end
        npc_op = 3'b100; epc = 32'h3204; #1;
        total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL eret_novalid got=%b exp=0", if_valid); end
        @(negedge clk);
        total++; if (pc !== 32'h3204) begin bad++; $display("FAIL eret_target got=%h exp=3204", pc); end
        stall = 1'b0; npc_op = 3'b000; #1;
        total++; if (if_valid !== 1'b1) begin bad++; $display("FAIL eret_resume got=%b exp=1", if_valid); end
        @(negedge clk);
        total++; if (pc !== 32'h3208) begin bad++; $display("FAIL eret_seq got=%h exp=3208", pc); end
    endtask

    task automatic test_adel();
        npc_op = 3'b011; rs_val = 32'h3002;
        @(negedge clk);
        npc_op = 3'b000; #1;
        total++; if (pc !== 32'h3002 || if_adel !== 1'b1 || if_valid !== 1'b0) begin bad++; $display("FAIL adel_misalign pc=%h adel=%b v=%b exp=3002/1/0", pc, if_adel, if_valid); end
        @(negedge clk);
        total++; if (pc !== 32'h3002) begin bad++; $display("FAIL adel_hold got=%h exp=3002", pc); end
        req = 1'b1;
        @(negedge clk);
        req = 1'b0; #1;
        total++; if (pc !== 32'h4180 || if_adel !== 1'b0) begin bad++; $display("FAIL adel_req pc=%h adel=%b exp=4180/0", pc, if_adel); end
        npc_op = 3'b011; rs_val = 32'h6FFC;
        @(negedge clk);
        npc_op = 3'b000; #1;
        total++; if (pc !== 32'h6FFC || if_adel !== 1'b0 || if_valid !== 1'b1) begin bad++; $display("FAIL adel_hi_edge pc=%h adel=%b v=%b exp=6ffc/0/1", pc, if_adel, if_valid); end
        @(negedge clk);
        total++; if (pc !== 32'h7000 || if_adel !== 1'b1 || if_valid !== 1'b0) begin bad++; $display("FAIL adel_above pc=%h adel=%b v=%b exp=7000/1/0", pc, if_adel, if_valid); end
        npc_op = 3'b011; rs_val = 32'h2FFC;
        @(negedge clk);
        total++; if (pc !== 32'h7000 || pend_valid !== 1'b1) begin bad++; $display("FAIL adel_capture pc=%h pend=%b exp=7000/1", pc, pend_valid); end
        npc_op = 3'b000; req = 1'b1;
        @(negedge clk);
        req = 1'b0; #1;
        total++; if (pc !== 32'h4180 || pend_valid !== 1'b0) begin bad++; $display("FAIL adel_recover pc=%h pend=%b exp=4180/0", pc, pend_valid); end
    endtask

    task automatic test_async_reset();
        if_ready = 1'b0; npc_op = 3'b011; rs_val = 32'h3100;
        @(negedge clk);
        total++; if (pend_valid !== 1'b1) begin bad++; $display("FAIL ar_setup pend=%b exp=1", pend_valid); end
        #2 rst_n = 1'b0; #1;
        total++; if (pc !== 32'h3000 || pend_valid !== 1'b0 || if_valid !== 1'b0) begin bad++; $display("FAIL async_reset pc=%h pend=%b v=%b exp=3000/0/0", pc, pend_valid, if_valid); end
        npc_op = 3'b000; if_ready = 1'b1;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        total++; if (pc !== 32'h3004) begin bad++; $display("FAIL ar_restart got=%h exp=3004", pc); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_branch_jump();
        test_pending_jr();
        test_req_over_pending();
        test_stall_eret();
        test_adel();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
